// File: rtl/tone_decoder.sv
// tone_decoder: measures the half-period of an asynchronous square wave and
// decodes it into one of eight piano notes (C4..C5).
//
// Ports:
//   CLK        in   system clock, all flops on the rising edge
//   RESET      in   asynchronous active-low reset
//   FREQ       in   asynchronous square-wave tone
//   NOTE       out  [7:0] one-hot note, bit7=C4 .. bit0=C5, 0 = none
//   NOTE_VALID out  high while a note is locked
//   NOTE_STB   out  one-cycle pulse whenever NOTE changes
//   seg        out  [7:0] active-low 7-segment pattern (only with TONE_DEC_SEG_EN)
//   an         out  [3:0] active-low digit enables (only with TONE_DEC_SEG_EN)
//
// Optional feature macro: TONE_DEC_SEG_EN adds the seg/an display outputs.
// A note locks after MATCH_N consecutive half-periods within TOL of its
// nominal HP_* value; MAX_HP cycles without an edge return to silence.

module tone_decoder #(
   parameter int HP_C4   = 191110,
   parameter int HP_D4   = 170265,
   parameter int HP_E4   = 151685,
   parameter int HP_F4   = 143172,
   parameter int HP_G4   = 127551,
   parameter int HP_A4   = 113636,
   parameter int HP_B4   = 101239,
   parameter int HP_C5   = 95557,
   parameter int TOL     = 1024,
   parameter int MATCH_N = 4,
   parameter int MAX_HP  = 262143
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       FREQ,
   output logic [7:0] NOTE,
   output logic       NOTE_VALID,
   output logic       NOTE_STB
`ifdef TONE_DEC_SEG_EN
   ,
   output logic [7:0] seg,
   output logic [3:0] an
`endif
);

   typedef enum logic [1:0] {
      SILENT  = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   // Nominal half-periods indexed by NOTE bit position.
   localparam int HP_TAB [0:7] = '{HP_C5, HP_B4, HP_A4, HP_G4, HP_F4, HP_E4, HP_D4, HP_C4};
   localparam logic [19:0] MAX_HP_C  = 20'(MAX_HP);
   localparam logic [3:0]  MATCH_C   = 4'(MATCH_N);

   // Returns the one-hot note whose nominal half-period is within TOL of the
   // measurement; scanning from bit 7 down makes the highest index win.
   function automatic logic [7:0] classify(input logic [19:0] meas);
      logic [7:0] hit;
      int         m;
      hit = 8'h00;
      m   = int'(meas);
      for (int i = 7; i >= 0; i--) begin
         if ((hit == 8'h00) && (m >= HP_TAB[i] - TOL) && (m <= HP_TAB[i] + TOL)) begin
            hit[i] = 1'b1;
         end else begin
            hit = hit;
         end
      end
      return hit;
   endfunction

`ifdef TONE_DEC_SEG_EN
   // Active-low segment pattern (bit0=a .. bit6=g, bit7=dp) for a note.
   function automatic logic [7:0] seg_of(input logic [7:0] note);
      logic [7:0] pat;
      case (note)
         8'b1000_0000: pat = 8'hC6;
         8'b0100_0000: pat = 8'hA1;
         8'b0010_0000: pat = 8'h86;
         8'b0001_0000: pat = 8'h8E;
         8'b0000_1000: pat = 8'hC2;
         8'b0000_0100: pat = 8'h88;
         8'b0000_0010: pat = 8'h83;
         8'b0000_0001: pat = 8'h46;
         default:      pat = 8'hFF;
      endcase
      return pat;
   endfunction
`endif

   logic        freq_s1_r, freq_s2_r, freq_d_r;
   logic        edge_s, timeout_s, lock_s;
   logic [19:0] hp_cnt_r, hp_cnt_n;
   logic [7:0]  cand_s;
   state_t      state_r, state_e, state_n;
   logic [3:0]  mcnt_r, mcnt_e, mcnt_n;
   logic [7:0]  cand_r, cand_e, cand_n;
   logic [7:0]  note_r, note_n;
   logic        valid_r, valid_n, stb_r;
`ifdef TONE_DEC_SEG_EN
   logic [7:0]  seg_r;
   logic [3:0]  an_r;
`endif

   // freq_d_r is the previous synchronized sample, used only for edge detection.
   assign edge_s    = freq_s2_r ^ freq_d_r;
   assign timeout_s = (hp_cnt_r == MAX_HP_C) && !edge_s;
   assign cand_s    = classify(hp_cnt_r);

   // Synchronizer and half-period counter.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         freq_s1_r <= 1'b0;
         freq_s2_r <= 1'b0;
         freq_d_r  <= 1'b0;
         hp_cnt_r  <= 20'd0;
      end else begin
         freq_s1_r <= FREQ;
         freq_s2_r <= freq_s1_r;
         freq_d_r  <= freq_s2_r;
         hp_cnt_r  <= hp_cnt_n;
      end
   end

   // Half-period counter next value: restart at 1 on an edge, saturate at MAX_HP.
   always_comb begin
      hp_cnt_n = hp_cnt_r;
      if (edge_s) begin
         hp_cnt_n = 20'd1;
      end else if (hp_cnt_r == MAX_HP_C) begin
         hp_cnt_n = hp_cnt_r;
      end else begin
         hp_cnt_n = hp_cnt_r + 20'd1;
      end
   end

   // Tracking decision for the current candidate, applied only in edge cycles.
   always_comb begin
      state_e = state_r;
      mcnt_e  = mcnt_r;
      cand_e  = cand_r;
      case (state_r)
         SILENT: begin
            if (cand_s != 8'h00) begin
               state_e = ACQUIRE;
               cand_e  = cand_s;
               mcnt_e  = 4'd1;
            end else begin
               state_e = SILENT;
            end
         end
         ACQUIRE: begin
            if (cand_s == 8'h00) begin
               cand_e = 8'h00;
               mcnt_e = 4'd0;
            end else if (cand_s == cand_r) begin
               mcnt_e = mcnt_r + 4'd1;
            end else begin
               cand_e = cand_s;
               mcnt_e = 4'd1;
            end
         end
         LOCKED: begin
            if (cand_s == note_r) begin
               state_e = LOCKED;
            end else if (cand_s == 8'h00) begin
               state_e = ACQUIRE;
               cand_e  = 8'h00;
               mcnt_e  = 4'd0;
            end else begin
               state_e = ACQUIRE;
               cand_e  = cand_s;
               mcnt_e  = 4'd1;
            end
         end
         default: begin
            state_e = SILENT;
            cand_e  = 8'h00;
            mcnt_e  = 4'd0;
         end
      endcase
   end

   // Lock completes in the same update that brings the match count to MATCH_N.
   assign lock_s = edge_s && (state_e == ACQUIRE) && (mcnt_e == MATCH_C);

   // Next-state/outputs: an edge has priority over the silence timeout.
   always_comb begin
      state_n = state_r;
      mcnt_n  = mcnt_r;
      cand_n  = cand_r;
      note_n  = note_r;
      valid_n = valid_r;
      if (lock_s) begin
         state_n = LOCKED;
         mcnt_n  = mcnt_e;
         cand_n  = cand_e;
         note_n  = cand_e;
         valid_n = 1'b1;
      end else if (edge_s) begin
         state_n = state_e;
         mcnt_n  = mcnt_e;
         cand_n  = cand_e;
      end else if (timeout_s) begin
         state_n = SILENT;
         mcnt_n  = 4'd0;
         cand_n  = 8'h00;
         note_n  = 8'h00;
         valid_n = 1'b0;
      end else begin
         state_n = state_r;
      end
   end

   // Tracking state and registered outputs.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_r <= SILENT;
         mcnt_r  <= 4'd0;
         cand_r  <= 8'h00;
         note_r  <= 8'h00;
         valid_r <= 1'b0;
         stb_r   <= 1'b0;
      end else begin
         state_r <= state_n;
         mcnt_r  <= mcnt_n;
         cand_r  <= cand_n;
         note_r  <= note_n;
         valid_r <= valid_n;
         stb_r   <= (note_n != note_r);
      end
   end

`ifdef TONE_DEC_SEG_EN
   // Display outputs registered alongside NOTE so they always agree.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         seg_r <= 8'hFF;
         an_r  <= 4'hF;
      end else begin
         seg_r <= seg_of(note_n);
         an_r  <= valid_n ? 4'b1110 : 4'b1111;
      end
   end

   assign seg = seg_r;
   assign an  = an_r;
`endif

   assign NOTE       = note_r;
   assign NOTE_VALID = valid_r;
   assign NOTE_STB   = stb_r;

endmodule

// File: tb/tb_tone_decoder.sv
// Testbench for tone_decoder with small half-periods. A reference model works
// on the sequence of FREQ toggles: each half-period is the distance between
// two toggles, classified against the note table, and its consequence becomes
// visible a fixed LAT clocks after the toggle is driven (2 synchronizer flops
// plus the output register).
module tb_tone_decoder;

   localparam int TOL     = 1;
   localparam int MATCH_N = 4;
   localparam int MAX_HP  = 100;
   localparam int LAT     = 3;

   logic       CLK;
   logic       RESET;
   logic       FREQ;
   logic [7:0] NOTE;
   logic       NOTE_VALID;
   logic       NOTE_STB;
`ifdef TONE_DEC_SEG_EN
   logic [7:0] seg;
   logic [3:0] an;
`endif

   tone_decoder #(
      .HP_C4(48), .HP_D4(42), .HP_E4(38), .HP_F4(34),
      .HP_G4(30), .HP_A4(26), .HP_B4(22), .HP_C5(18),
      .TOL(TOL), .MATCH_N(MATCH_N), .MAX_HP(MAX_HP)
   ) dut (
      .CLK(CLK), .RESET(RESET), .FREQ(FREQ),
      .NOTE(NOTE), .NOTE_VALID(NOTE_VALID), .NOTE_STB(NOTE_STB)
`ifdef TONE_DEC_SEG_EN
      , .seg(seg), .an(an)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int since = 0;
   int last_d;
   int tq[$];
   int stb_seen, valid_seen, zero_seen;

   // Nominal half-period per NOTE bit (bit7=C4 .. bit0=C5).
   int ref_hp [8] = '{18, 22, 26, 30, 34, 38, 42, 48};

   // Reference model state.
   int         m_phase;   // 0 silent, 1 acquiring, 2 locked
   logic [7:0] m_note, m_cand;
   int         m_cnt;
   logic       m_valid;
   logic       exp_stb;

   function automatic logic [7:0] ref_class(input int hp);
      logic [7:0] r;
      int d;
      r = 8'h00;
      for (int b = 7; b >= 0; b--) begin
         d = hp - ref_hp[b];
         if (d < 0) d = -d;
         if (r == 8'h00 && d <= TOL) r[b] = 1'b1;
      end
      return r;
   endfunction

   function automatic logic [7:0] ref_seg(input logic [7:0] n);
      case (n)
         8'h80: return 8'hC6;
         8'h40: return 8'hA1;
         8'h20: return 8'h86;
         8'h10: return 8'h8E;
         8'h08: return 8'hC2;
         8'h04: return 8'h88;
         8'h02: return 8'h83;
         8'h01: return 8'h46;
         default: return 8'hFF;
      endcase
   endfunction

   task automatic model_reset();
      m_phase = 0; m_note = 8'h00; m_cand = 8'h00; m_cnt = 0; m_valid = 1'b0;
      tq.delete();
   endtask

   task automatic model_edge(input int hp);
      logic [7:0] c;
      c = ref_class(hp);
      if (m_phase == 2 && c == m_note) begin
         m_phase = 2;
      end else if (c == 8'h00) begin
         if (m_phase != 0) begin m_phase = 1; m_cand = 8'h00; m_cnt = 0; end
      end else if (m_phase == 1 && c == m_cand) begin
         m_cnt++;
      end else begin
         m_phase = 1; m_cand = c; m_cnt = 1;
      end
      if (m_phase == 1 && m_cnt == MATCH_N) begin
         m_phase = 2; m_note = m_cand; m_valid = 1'b1;
      end
   endtask

   // One clock: advance the model, compare outputs #1 after the edge, then
   // optionally toggle FREQ.
   task automatic tick(input bit tog);
      logic [7:0] prev;
      int d, hp;
      @(posedge CLK);
      cyc++;
      prev = m_note;
      if (RESET) begin
         if (tq.size() > 0 && tq[0] + LAT == cyc) begin
            d = tq.pop_front();
            hp = d - last_d;
            if (hp > MAX_HP) hp = MAX_HP;
            last_d = d;
            model_edge(hp);
         end else if (cyc - LAT - last_d >= MAX_HP) begin
            m_phase = 0; m_note = 8'h00; m_cand = 8'h00; m_cnt = 0; m_valid = 1'b0;
         end
      end
      exp_stb = (m_note != prev);
      #1;
      total++;
      if (NOTE !== m_note) begin bad++; $display("FAIL note cyc=%0d got=%b exp=%b", cyc, NOTE, m_note); end
      total++;
      if (NOTE_VALID !== m_valid) begin bad++; $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, NOTE_VALID, m_valid); end
      total++;
      if (NOTE_STB !== exp_stb) begin bad++; $display("FAIL stb cyc=%0d got=%b exp=%b", cyc, NOTE_STB, exp_stb); end
`ifdef TONE_DEC_SEG_EN
      total++;
      if (seg !== ref_seg(m_note)) begin bad++; $display("FAIL seg cyc=%0d got=%h exp=%h", cyc, seg, ref_seg(m_note)); end
      total++;
      if (an !== (m_valid ? 4'b1110 : 4'b1111)) begin bad++; $display("FAIL an cyc=%0d got=%h valid=%b", cyc, an, m_valid); end
`endif
      if (NOTE_STB === 1'b1) stb_seen++;
      if (NOTE_VALID === 1'b1) valid_seen++;
      if (NOTE === 8'h00) zero_seen++;
      since++;
      if (tog) begin
         FREQ = ~FREQ;
         since = 0;
         if (RESET) tq.push_back(cyc);
      end
   endtask

   // n toggles spaced hp clocks apart (the first measured from the last toggle).
   task automatic send_hp(input int hp, input int n);
      for (int k = 0; k < n; k++) begin
         while (since + 1 < hp) tick(1'b0);
         tick(1'b1);
      end
   endtask

   task automatic release_reset();
      FREQ = 1'b0;
      RESET = 1'b1;
      last_d = cyc - 1000;
      repeat (120) tick(1'b0);
   endtask

   task automatic test_reset();
      stb_seen = 0; valid_seen = 0;
      for (int i = 1; i <= 160; i++) tick((i % 38) == 0);
      total++;
      if (stb_seen != 0 || valid_seen != 0) begin
         bad++; $display("FAIL reset_quiet got stb=%0d valid=%0d exp 0/0", stb_seen, valid_seen);
      end
      release_reset();
   endtask

   task automatic test_lock();
      stb_seen = 0;
      send_hp(38, 5);
      repeat (4) tick(1'b0);
      total++;
      if (NOTE !== 8'b0010_0000 || NOTE_VALID !== 1'b1 || stb_seen != 1) begin
         bad++; $display("FAIL lock_e got note=%b valid=%b stb=%0d exp 00100000/1/1", NOTE, NOTE_VALID, stb_seen);
      end
   endtask

   task automatic test_switch();
      stb_seen = 0; zero_seen = 0;
      send_hp(30, 3);
      repeat (4) tick(1'b0);
      total++;
      if (NOTE !== 8'b0010_0000 || stb_seen != 0) begin
         bad++; $display("FAIL switch_hold got note=%b stb=%0d exp 00100000/0", NOTE, stb_seen);
      end
      send_hp(30, 1);
      repeat (4) tick(1'b0);
      total++;
      if (NOTE !== 8'b0000_1000 || stb_seen != 1 || zero_seen != 0) begin
         bad++; $display("FAIL switch_g got note=%b stb=%0d zero=%0d exp 00001000/1/0", NOTE, stb_seen, zero_seen);
      end
   endtask

   task automatic test_timeout();
      stb_seen = 0;
      while (since < LAT + MAX_HP - 1) tick(1'b0);
      total++;
      if (NOTE !== 8'b0000_1000 || NOTE_VALID !== 1'b1) begin
         bad++; $display("FAIL timeout_early got note=%b valid=%b exp 00001000/1", NOTE, NOTE_VALID);
      end
      tick(1'b0);
      total++;
      if (NOTE !== 8'h00 || NOTE_VALID !== 1'b0 || NOTE_STB !== 1'b1) begin
         bad++; $display("FAIL timeout_at got note=%b valid=%b stb=%b exp 0/0/1", NOTE, NOTE_VALID, NOTE_STB);
      end
      repeat (20) tick(1'b0);
      total++;
      if (stb_seen != 1) begin bad++; $display("FAIL timeout_stb got=%0d exp=1", stb_seen); end
   endtask

   task automatic test_no_lock();
      stb_seen = 0; valid_seen = 0;
      send_hp(45, 12);
      for (int i = 0; i < 6; i++) begin
         send_hp(38, 1);
         send_hp(42, 1);
      end
      total++;
      if (valid_seen != 0 || stb_seen != 0) begin
         bad++; $display("FAIL no_lock got valid=%0d stb=%0d exp 0/0", valid_seen, stb_seen);
      end
   endtask

   // A gap of exactly MAX_HP is still an edge; one more clock is a timeout.
   task automatic test_boundary();
      send_hp(30, 6);
      send_hp(MAX_HP, 1);
      repeat (4) tick(1'b0);
      total++;
      if (NOTE !== 8'b0000_1000 || NOTE_VALID !== 1'b1) begin
         bad++; $display("FAIL gap_max got note=%b valid=%b exp 00001000/1", NOTE, NOTE_VALID);
      end
      send_hp(MAX_HP + 1, 1);
      repeat (4) tick(1'b0);
      total++;
      if (NOTE !== 8'h00 || NOTE_VALID !== 1'b0) begin
         bad++; $display("FAIL gap_over got note=%b valid=%b exp 0/0", NOTE, NOTE_VALID);
      end
   endtask

   task automatic test_reset_relock();
      send_hp(30, 6);
      repeat (4) tick(1'b0);
      total++;
      if (NOTE !== 8'b0000_1000) begin bad++; $display("FAIL pre_reset got=%b exp=00001000", NOTE); end
      RESET = 1'b0;
      #1;
      total++;
      if (NOTE !== 8'h00 || NOTE_VALID !== 1'b0 || NOTE_STB !== 1'b0) begin
         bad++; $display("FAIL async_reset got note=%b valid=%b stb=%b exp 0/0/0", NOTE, NOTE_VALID, NOTE_STB);
      end
      model_reset();
      repeat (5) tick(1'b0);
      release_reset();
      send_hp(30, 4);
      repeat (4) tick(1'b0);
      total++;
      if (NOTE_VALID !== 1'b0) begin bad++; $display("FAIL early_relock got=%b exp=0", NOTE_VALID); end
      send_hp(30, 1);
      repeat (4) tick(1'b0);
      total++;
      if (NOTE !== 8'b0000_1000 || NOTE_VALID !== 1'b1) begin
         bad++; $display("FAIL relock got note=%b valid=%b exp 00001000/1", NOTE, NOTE_VALID);
      end
   endtask

   task automatic test_random();
      int r;
      for (int s = 0; s < 40; s++) begin
         r = $urandom_range(0, 9);
         if (r < 7) send_hp(ref_hp[$urandom_range(0, 7)], $urandom_range(1, 7));
         else if (r < 9) send_hp($urandom_range(12, 60), $urandom_range(1, 3));
         else send_hp($urandom_range(95, 110), 1);
      end
      repeat (130) tick(1'b0);
      total++;
      if (NOTE !== 8'h00 || NOTE_VALID !== 1'b0) begin
         bad++; $display("FAIL random_end got note=%b valid=%b exp 0/0", NOTE, NOTE_VALID);
      end
   endtask

   initial begin
      RESET = 1'b0;
      FREQ  = 1'b0;
      last_d = -1000;
      model_reset();
      test_reset();
      test_lock();
      test_switch();
      test_timeout();
      test_no_lock();
      test_boundary();
      test_reset_relock();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tone_decoder.md
TONE_DECODER -- requirements
Module: tone_decoder

Interface
REQ-001 SHALL have parameter HP_C4, default 191110, expected half-period in CLK cycles for C4 (sw[7] note).
REQ-002 SHALL have parameters HP_D4/HP_E4/HP_F4/HP_G4/HP_A4/HP_B4/HP_C5, defaults 170265/151685/143172/127551/113636/101239/95557, for sw[6]..sw[0] notes.
REQ-003 SHALL have parameter TOL, default 1024, allowed absolute deviation from any HP_* value, in cycles.
REQ-004 SHALL have parameter MATCH_N, default 4, number of consecutive matching half-periods needed to lock (1..15).
REQ-005 SHALL have parameter MAX_HP, default 262143, silence timeout in cycles (≤ 2^20-1, > every HP_*+TOL).
REQ-006 SHALL have CLK  input  1  system clock; all flops on its rising edge.
REQ-007 SHALL have RESET  input  1  asynchronous, active-low reset.
REQ-008 SHALL have FREQ  input  1  asynchronous square-wave tone from the piano output.
REQ-009 SHALL have NOTE  output  8  one-hot decoded note; bit positions equal the piano sw[] positions (bit7=C4 .. bit0=C5); 0 = none.
REQ-010 SHALL have NOTE_VALID  output  1  high while a note is locked.
REQ-011 SHALL have NOTE_STB  output  1  one-cycle pulse whenever NOTE changes value.

Function
REQ-012 FREQ SHALL pass a 2-flop synchronizer; a rising or falling edge of the synchronized signal is one "edge" event.
REQ-013 20-bit hp_cnt SHALL load 1 on each edge cycle, otherwise increment, saturating at MAX_HP; measured half-period = hp_cnt value in the edge cycle.
REQ-014 On edge, candidate SHALL be the note whose |measured - HP_*| ≤ TOL; on multiple matches, the highest NOTE bit index wins; no match gives candidate 0.
REQ-015 States SHALL be SILENT, ACQUIRE, LOCKED; a 4-bit match counter mcnt and a candidate register cand are kept.
REQ-016 SILENT: NOTE=0, NOTE_VALID=0; edge with nonzero candidate -> ACQUIRE, cand=candidate, mcnt=1; otherwise stay.
REQ-017 ACQUIRE: edge with candidate==cand -> mcnt+1; edge with other nonzero candidate -> cand=candidate, mcnt=1; edge with candidate 0 -> mcnt=0, stay in ACQUIRE with cand cleared (next nonzero edge restarts at mcnt=1).
REQ-018 When mcnt reaches MATCH_N, the SHALL register on the following cycle: state LOCKED, NOTE=cand, NOTE_VALID=1, NOTE_STB=1 if NOTE differs from its prior value.
REQ-019 LOCKED: edge with candidate==NOTE -> stay; any other candidate -> ACQUIRE per REQ-017 with NOTE and NOTE_VALID held until a new lock or timeout.
REQ-020 Timeout: in any state, hp_cnt==MAX_HP with no edge -> SILENT next cycle; NOTE=0, NOTE_VALID=0, NOTE_STB=1 if NOTE was nonzero.
REQ-021 Edge and timeout in the same cycle: edge SHALL take priority.
REQ-022 The first edge after silence measures MAX_HP and SHALL never match.

Reset
REQ-023 RESET low SHALL immediately force state SILENT, hp_cnt=0, mcnt=0, cand=0, synchronizer flops=0, NOTE=0, NOTE_VALID=0, NOTE_STB=0 (and seg=8'hFF, an=4'hF when enabled); reset mid-lock requires a full MATCH_N re-acquire.

Configuration
REQ-024 With TONE_DEC_SEG_EN defined, SHALL add outputs seg[7:0] (active-low, bit0=a..bit6=g, bit7=dp) and an[3:0] (active-low), registered together with NOTE.
REQ-025 With TONE_DEC_SEG_EN, seg SHALL be C4=C6, D4=A1, E4=86, F4=8E, G4=C2, A4=88, B4=83, C5=46 (hex), none=FF; an=4'b1110 when NOTE_VALID else 4'b1111.
REQ-026 Without TONE_DEC_SEG_EN, the seg/an ports and their logic SHALL be absent; all other behaviour is identical.

Verification (bench params: HP 48,42,38,34,30,26,22,18; TOL=1; MATCH_N=4; MAX_HP=100)
REQ-027 RESET low, FREQ toggling every 38 cycles -> NOTE=0, NOTE_VALID=0, NOTE_STB=0, seg=FF, an=F throughout.
REQ-028 Release reset, FREQ half-period 38 -> after the 4th matching edge NOTE=8'b0010_0000, NOTE_VALID=1, exactly one NOTE_STB pulse, seg=86, an=E.
REQ-029 While locked on E, switch to half-period 30 -> NOTE holds 0010_0000 for 3 edges, then becomes 0000_1000 with one NOTE_STB pulse and no cycle of NOTE=0.
REQ-030 Locked, FREQ held constant -> exactly 100 cycles after the last edge NOTE=0, NOTE_VALID=0, single NOTE_STB pulse.
REQ-031 Half-period 45 or alternating 38/42 per edge -> NOTE_VALID never asserts, NOTE_STB never pulses.
REQ-032 RESET pulsed low while locked on G -> outputs zero asynchronously; after release, relock on G only after 4 matching edges.
